// File: rtl/tone_detector.sv
// rtl/tone_detector.sv - five-channel tone detector producing locked junction commands
// Per-window rising-edge counts are classified; one in-band tone must persist to lock.
module tone_detector #(
  parameter int WINDOW_CYCLES   = 500_000,
  parameter int MIN_EDGES       = 8,
  parameter int MAX_EDGES       = 200,
  parameter int CONFIRM_WINDOWS = 3,
  parameter int RELEASE_WINDOWS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  output logic       tdEn,
  output logic [1:0] tdDir,
  output logic       tdStop,
  output logic       tdNew
);

  localparam int               WIN_W    = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [7:0]       MIN_E    = 8'(MIN_EDGES);
  localparam logic [7:0]       MAX_E    = 8'(MAX_EDGES);
  localparam logic [7:0]       CONF_N   = 8'(CONFIRM_WINDOWS);
  localparam logic [7:0]       REL_N    = 8'(RELEASE_WINDOWS);
  localparam logic [2:0]       CH_STOP  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_CAND, S_LOCKED} state_t;

  logic [4:0]       w_bp;
  logic [4:0]       r_sync1;
  logic [4:0]       r_sync2;
  logic [4:0]       r_sync_d;
  logic [4:0]       w_edge;
  logic [WIN_W-1:0] r_win_cnt;
  logic             w_win_end;
  logic [7:0]       r_cnt [5];
  logic [4:0]       w_present;
  logic [2:0]       w_npres;
  logic [2:0]       w_idx;
  logic             w_valid;

  state_t     r_state, w_state_n;
  logic [2:0] r_cand, w_cand_n;
  logic [7:0] r_conf, w_conf_n;
  logic [7:0] r_rel, w_rel_n;
  logic [2:0] r_lock, w_lock_n;
  logic       r_en, w_en_n;
  logic [1:0] r_dir, w_dir_n;
  logic       r_stop, w_stop_n;
  logic       r_new, w_new_n;
  logic       w_take;

  assign w_bp   = {bp5, bp4, bp3, bp2, bp1};
  assign w_edge = r_sync2 & ~r_sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync_d <= '0;
    end else begin
      r_sync1  <= w_bp;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_win_end = (r_win_cnt == WIN_LAST);

  always_ff @(posedge clk) begin
    if (rst || w_win_end) begin
      r_win_cnt <= '0;
    end else begin
      r_win_cnt <= r_win_cnt + 1'b1;
    end
  end

  // An edge landing on the window-end cycle is credited to the new window.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rst) begin
        r_cnt[i] <= 8'd0;
      end else if (w_win_end) begin
        r_cnt[i] <= {7'd0, w_edge[i]};
      end else if (w_edge[i] && (r_cnt[i] != 8'hFF)) begin
        r_cnt[i] <= r_cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    w_present = '0;
    w_npres   = 3'd0;
    w_idx     = 3'd0;
    for (int i = 0; i < 5; i++) begin
      w_present[i] = (r_cnt[i] >= MIN_E) && (r_cnt[i] <= MAX_E);
      if (w_present[i]) begin
        w_npres = w_npres + 3'd1;
        w_idx   = 3'(i);
      end
    end
    w_valid = (w_npres == 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cand  <= 3'd0;
      r_conf  <= 8'd0;
      r_rel   <= 8'd0;
      r_lock  <= 3'd0;
      r_en    <= 1'b0;
      r_dir   <= 2'b00;
      r_stop  <= 1'b0;
      r_new   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cand  <= w_cand_n;
      r_conf  <= w_conf_n;
      r_rel   <= w_rel_n;
      r_lock  <= w_lock_n;
      r_en    <= w_en_n;
      r_dir   <= w_dir_n;
      r_stop  <= w_stop_n;
      r_new   <= w_new_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cand_n  = r_cand;
    w_conf_n  = r_conf;
    w_rel_n   = r_rel;
    w_lock_n  = r_lock;
    w_en_n    = r_en;
    w_dir_n   = r_dir;
    w_stop_n  = r_stop;
    w_new_n   = 1'b0;
    w_take    = 1'b0;
    if (w_win_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            if (CONF_N <= 8'd1) begin
              w_take = 1'b1;
            end else begin
              w_cand_n  = w_idx;
              w_conf_n  = 8'd1;
              w_state_n = S_CAND;
            end
          end
        end
        S_CAND: begin
          if (!w_valid) begin
            w_state_n = S_IDLE;
            w_conf_n  = 8'd0;
          end else if (w_idx == r_cand) begin
            if (r_conf + 8'd1 >= CONF_N) begin
              w_take = 1'b1;
            end else begin
              w_conf_n = r_conf + 8'd1;
            end
          end else begin
            w_cand_n = w_idx;
            w_conf_n = 8'd1;
          end
        end
        S_LOCKED: begin
          // A different tone only counts toward release; relock goes through IDLE.
          if (w_valid && (w_idx == r_lock)) begin
            w_rel_n = 8'd0;
          end else if (r_rel + 8'd1 >= REL_N) begin
            w_state_n = S_IDLE;
            w_rel_n   = 8'd0;
            w_en_n    = 1'b0;
            w_stop_n  = 1'b0;
          end else begin
            w_rel_n = r_rel + 8'd1;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
    if (w_take) begin
      w_state_n = S_LOCKED;
      w_lock_n  = w_idx;
      w_rel_n   = 8'd0;
      w_conf_n  = 8'd0;
      w_new_n   = 1'b1;
      if (w_idx == CH_STOP) begin
        w_stop_n = 1'b1;
        w_en_n   = 1'b0;
      end else begin
        w_en_n   = 1'b1;
        w_dir_n  = w_idx[1:0];
        w_stop_n = 1'b0;
      end
    end
  end

  assign tdEn   = r_en;
  assign tdDir  = r_dir;
  assign tdStop = r_stop;
  assign tdNew  = r_new;

endmodule

// File: tb/tb_tone_detector.sv
// tb/tb_tone_detector.sv - directed window-aligned tone stimulus for tone_detector
module tb_tone_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       bp1 = 1'b0;
  logic       bp2 = 1'b0;
  logic       bp3 = 1'b0;
  logic       bp4 = 1'b0;
  logic       bp5 = 1'b0;
  logic       tdEn;
  logic [1:0] tdDir;
  logic       tdStop;
  logic       tdNew;

  int         n_pass  = 0;
  int         n_total = 0;
  int         elapsed = 0;
  int         half [5] = '{default: 0};
  int         ph   [5] = '{default: 0};
  logic [4:0] v = '0;

  tone_detector #(
    .WINDOW_CYCLES  (1000),
    .MIN_EDGES      (4),
    .MAX_EDGES      (20),
    .CONFIRM_WINDOWS(3),
    .RELEASE_WINDOWS(2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bp1   (bp1),
    .bp2   (bp2),
    .bp3   (bp3),
    .bp4   (bp4),
    .bp5   (bp5),
    .tdEn  (tdEn),
    .tdDir (tdDir),
    .tdStop(tdStop),
    .tdNew (tdNew)
  );

  always #5 clk = ~clk;

  // Square-wave generators: half[i] negedges per half period, 0 = silent.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        if (half[i] == 0) begin
          v[i]  = 1'b0;
          ph[i] = 0;
        end else begin
          ph[i] = ph[i] + 1;
          if (ph[i] >= half[i]) begin
            ph[i] = 0;
            v[i]  = ~v[i];
          end
        end
      end
      bp1 = v[0];
      bp2 = v[1];
      bp3 = v[2];
      bp4 = v[3];
      bp5 = v[4];
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to k windows plus off cycles after reset release, sampling 1 unit past the edge.
  task automatic at_win(input int k, input int off);
    int n;
    n = k * 1000 + off - elapsed;
    repeat (n) begin
      @(posedge clk);
      elapsed++;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_en", {7'd0, tdEn}, 8'd0);
    chk("rst_dir", {6'd0, tdDir}, 8'd0);
    chk("rst_stop", {7'd0, tdStop}, 8'd0);
    chk("rst_new", {7'd0, tdNew}, 8'd0);

    half[1] = 50;
    @(negedge clk);
    rst     = 1'b0;
    elapsed = 0;

    at_win(2, 999);
    chk("left_prelock_en", {7'd0, tdEn}, 8'd0);
    at_win(3, 0);
    chk("left_en", {7'd0, tdEn}, 8'd1);
    chk("left_dir", {6'd0, tdDir}, 8'd1);
    chk("left_new", {7'd0, tdNew}, 8'd1);
    chk("left_stop", {7'd0, tdStop}, 8'd0);
    at_win(3, 1);
    chk("left_new_pulse", {7'd0, tdNew}, 8'd0);

    at_win(4, 1);
    half[1] = 0;
    at_win(5, 0);
    chk("rel1_en", {7'd0, tdEn}, 8'd1);
    at_win(6, 0);
    chk("rel2_en", {7'd0, tdEn}, 8'd0);
    chk("rel2_dir", {6'd0, tdDir}, 8'd1);

    at_win(6, 1);
    half[2] = 200;
    for (int w = 7; w <= 26; w++) begin
      at_win(w, 0);
      chk("oob", {5'd0, tdEn, tdStop, tdNew}, 8'd0);
      if (w == 16) begin
        at_win(16, 1);
        half[2] = 17;
      end
    end
    at_win(26, 1);
    half[2] = 0;

    half[0] = 50;
    half[3] = 50;
    for (int w = 27; w <= 30; w++) begin
      at_win(w, 0);
      chk("ambig", {5'd0, tdEn, tdStop, tdNew}, 8'd0);
    end
    at_win(30, 1);
    half[3] = 0;
    at_win(32, 1);
    half[0] = 0;
    half[3] = 50;
    at_win(34, 0);
    chk("restart_prelock_en", {7'd0, tdEn}, 8'd0);
    at_win(35, 0);
    chk("back_en", {7'd0, tdEn}, 8'd1);
    chk("back_dir", {6'd0, tdDir}, 8'd3);
    chk("back_new", {7'd0, tdNew}, 8'd1);
    at_win(35, 1);
    half[3] = 0;
    at_win(37, 0);
    chk("back_rel_en", {7'd0, tdEn}, 8'd0);

    at_win(37, 1);
    half[4] = 50;
    at_win(39, 0);
    chk("stop_prelock", {7'd0, tdStop}, 8'd0);
    at_win(40, 0);
    chk("stop_stop", {7'd0, tdStop}, 8'd1);
    chk("stop_en", {7'd0, tdEn}, 8'd0);
    chk("stop_dir", {6'd0, tdDir}, 8'd3);
    chk("stop_new", {7'd0, tdNew}, 8'd1);
    at_win(40, 1);
    half[4] = 0;
    at_win(42, 0);
    chk("stop_rel", {7'd0, tdStop}, 8'd0);

    at_win(42, 1);
    half[0] = 1;
    for (int w = 43; w <= 46; w++) begin
      at_win(w, 0);
      chk("saturate", {5'd0, tdEn, tdStop, tdNew}, 8'd0);
    end
    at_win(46, 1);
    half[0] = 0;

    half[2] = 50;
    at_win(49, 0);
    chk("right_en", {7'd0, tdEn}, 8'd1);
    chk("right_dir", {6'd0, tdDir}, 8'd2);
    chk("right_new", {7'd0, tdNew}, 8'd1);
    at_win(49, 500);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_outs", {3'd0, tdEn, tdDir, tdStop, tdNew}, 8'd0);
    @(negedge clk);
    rst     = 1'b0;
    elapsed = 0;
    at_win(2, 999);
    chk("relock_pre_en", {7'd0, tdEn}, 8'd0);
    at_win(3, 0);
    chk("relock_en", {7'd0, tdEn}, 8'd1);
    chk("relock_dir", {6'd0, tdDir}, 8'd2);
    chk("relock_new", {7'd0, tdNew}, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
